trig_surf_gather: RTL and testbench
===================================

TRIG_SURF_GATHER -- requirements
Module: trig_surf_gather

Interface
REQ-001 SHALL have parameter NTIO, default 4, number of TURFIOs.
REQ-002 SHALL have parameter SURFS_PER_TIO, default 7, real SURFs per TURFIO.
REQ-003 SHALL have parameter LANES_PER_TIO, default 8, input lanes per TURFIO; unused lanes (index >= SURFS_PER_TIO) are ignored.
REQ-004 SHALL have parameter SLOTS, default 2, 1-4, trigger slots per 8-clock command cycle.
REQ-005 SHALL have parameter SLOT_OFFSET, default 3, 0-7, clocks from phase to slot 0.
REQ-006 SHALL have parameter SLOT_SPACING, default 4, 1-7, clocks between slots, modulo 8.
REQ-007 SHALL have port sysclk_i, input, 1, sole clock.
REQ-008 SHALL have port sysclk_rst_i, input, 1, reset, asynchronous, active-high.
REQ-009 SHALL have port sysclk_phase_i, input, 1, high on clock 0 of the 8-clock command cycle.
REQ-010 SHALL have port trig_dat_i, input, NTIO*LANES_PER_TIO*16, 16-bit word per lane; lane L of TIO t at bits [16*(LANES_PER_TIO*t+L) +: 16].
REQ-011 SHALL have port trig_mask_i, input, NTIO*SURFS_PER_TIO (NS), 1 = SURF disabled; compacted SURF index s = SURFS_PER_TIO*t+L.
REQ-012 SHALL have ports m_trig_tdata (output, 24), m_trig_tvalid (output, 1), m_trig_tlast (output, 1), m_trig_tready (input, 1): AXI4-Stream master.
REQ-013 SHALL have port overflow_count_o, output, 16, saturating dropped-capture count.
REQ-014 SHALL have port overflow_clr_i, input, 1, synchronous clear of overflow_count_o.
REQ-015 SHALL have port phase_err_o, output, 1, sticky phase-spacing error.

Function
REQ-016 SHALL keep 3-bit cycle counter cnt: phase high -> cnt<=1, else cnt<=cnt+1; position pos = phase ? 0 : cnt.
REQ-017 SHALL hold locked=0 after reset; first phase sets locked=1; no capture while locked=0.
REQ-018 SHALL define slot k (0..SLOTS-1) as pos == (SLOT_OFFSET + k*SLOT_SPACING) mod 8.
REQ-019 SHALL, on a slot clock with locked=1, register all NS compacted words and pending[s] = word[15] && !trig_mask_i[s].
REQ-020 SHALL treat an all-zero pending result as no capture: no output, no overflow.
REQ-021 SHALL drive m_trig_tvalid high the clock after a capture with nonzero pending.
REQ-022 SHALL present lowest set pending index s: tdata[15:0]=word[s], tdata[23:16]=s zero-extended; tlast=1 iff s is the only set bit.
REQ-023 SHALL, on tvalid&&tready, clear pending[s] and present the next lowest index the following clock; tvalid drops after the tlast beat; one beat per clock sustained.
REQ-024 SHALL hold tdata/tlast stable while tvalid&&!tready.
REQ-025 SHALL, on a slot clock when pending is nonzero after this clock's handshake, drop the new capture and increment overflow_count_o, saturating at 0xFFFF.
REQ-026 SHALL accept a new capture when the tlast handshake coincides with the slot clock; no overflow.
REQ-027 SHALL make overflow_clr_i dominate; clear coincident with an overflow yields count 1.
REQ-028 SHALL sample trig_mask_i only on slot clocks; mask changes do not alter pending entries.

Reset
REQ-029 SHALL, on sysclk_rst_i, asynchronously clear cnt, locked, pending, m_trig_tvalid, m_trig_tlast, m_trig_tdata, overflow_count_o, phase_err_o; in-flight entries are discarded without tlast.

Configuration
REQ-030 SHALL, with TRIG_SURF_GATHER_PHASE_CHECK_EN defined, set phase_err_o when locked=1 and phase arrives with cnt!=0, or cnt==0 with phase low; sticky until reset; cnt still resyncs per REQ-016.
REQ-031 SHALL, without TRIG_SURF_GATHER_PHASE_CHECK_EN, tie phase_err_o to 0 and omit the check logic.

Verification
REQ-032 SHALL cover: reset; phase every 8 clocks; SURF 5 word 0x8123 at pos 3 -> one beat tdata=0x058123, tlast=1, tvalid at pos 4.
REQ-033 SHALL cover: SURFs 0, 9, 27 words 0x8001/0x8002/0x8003, tready=1 -> beats 0x008001, 0x098002, 0x1B8003 on consecutive clocks; tlast on the third.
REQ-034 SHALL cover: SURF 9 masked, SURFs 9 and 10 triggered -> single beat 0x0A....; word with bit15=0 -> no beat.
REQ-035 SHALL cover: tready=0 through pos 7 with capture pending -> overflow_count_o=1, pending data unchanged; 0xFFFF held over further overflows; clr+overflow -> 1.
REQ-036 SHALL cover: phase before first phase blocked (no capture); with macro, phase shifted by 2 clocks -> phase_err_o=1, sticky; without macro, stays 0.
REQ-037 SHALL cover: reset asserted mid-burst (beat 2 of 3) -> tvalid=0 same clock; no output until phase.

Source files
------------

// File: rtl/trig_surf_gather_if.sv
// Trigger output stream interface: AXI4-Stream style beat carrying a 16-bit
// SURF trigger word plus its 8-bit compacted SURF index.
//   tdata[15:0]  : trigger word
//   tdata[23:16] : compacted SURF index
//   tvalid/tready: handshake
//   tlast        : final beat of one capture
interface trig_surf_gather_if;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/trig_surf_gather.sv
// Trigger SURF gather.
// Captures the 16-bit trigger words of every real SURF on the trigger slot
// clocks of the 8-clock command cycle and streams the SURFs whose word has
// bit 15 set (and that are not masked) out one beat per clock, lowest SURF
// index first. A capture that arrives while an earlier one is still being
// streamed is dropped and counted.
//
// Ports:
//   sysclk_i          : sole clock
//   sysclk_rst_i      : asynchronous active-high reset
//   sysclk_phase_i    : high on clock 0 of the 8-clock command cycle
//   trig_dat_i        : 16-bit word per lane, lane L of TIO t at
//                       [16*(LANES_PER_TIO*t+L) +: 16]
//   trig_mask_i       : per compacted SURF, 1 = disabled
//   m_trig            : trigger stream master (tdata/tvalid/tlast/tready)
//   overflow_count_o  : saturating count of dropped captures
//   overflow_clr_i    : synchronous clear of overflow_count_o (dominant)
//   phase_err_o       : sticky phase-spacing error
//
// Build option: define TRIG_SURF_GATHER_PHASE_CHECK_EN to enable the phase
// spacing check; otherwise phase_err_o is tied low.
module trig_surf_gather #(
  parameter int unsigned NTIO          = 4,
  parameter int unsigned SURFS_PER_TIO = 7,
  parameter int unsigned LANES_PER_TIO = 8,
  parameter int unsigned SLOTS         = 2,
  parameter int unsigned SLOT_OFFSET   = 3,
  parameter int unsigned SLOT_SPACING  = 4
) (
  input  logic                            sysclk_i,
  input  logic                            sysclk_rst_i,
  input  logic                            sysclk_phase_i,
  input  logic [NTIO*LANES_PER_TIO*16-1:0] trig_dat_i,
  input  logic [NTIO*SURFS_PER_TIO-1:0]    trig_mask_i,
  trig_surf_gather_if.master               m_trig,
  output logic [15:0]                      overflow_count_o,
  input  logic                             overflow_clr_i,
  output logic                             phase_err_o
);

  localparam int unsigned NS = NTIO * SURFS_PER_TIO;

  // Command-cycle position tracking
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] pos;
  logic       locked_q, locked_d;
  logic       slot_hit;

  // Capture / streaming state
  logic [NS-1:0] pend_q, pend_d;
  logic [NS-1:0] new_pend;
  logic [NS-1:0] pend_left;
  logic [NS-1:0] low_onehot;
  logic [15:0]   words_q   [NS];
  logic [15:0]   new_words [NS];
  logic          handshake;
  logic          capture;
  logic          accept;
  logic          overflow;

  logic [15:0]   overflow_count_q, overflow_count_d;

  logic [7:0]    sel_idx;
  logic [15:0]   sel_word;

  // Lanes at or above SURFS_PER_TIO carry no SURF and are ignored.
  logic unused_dat;
  assign unused_dat = ^trig_dat_i;

  always_comb begin
    pos      = sysclk_phase_i ? 3'd0 : cnt_q;
    cnt_d    = sysclk_phase_i ? 3'd1 : cnt_q + 3'd1;
    locked_d = locked_q | sysclk_phase_i;
  end

  always_comb begin
    slot_hit = 1'b0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (pos == 3'((SLOT_OFFSET + k * SLOT_SPACING) % 8)) begin
        slot_hit = 1'b1;
      end
    end
    slot_hit = slot_hit & locked_q;
  end

  // Compact the real SURF lanes into a dense index s = SURFS_PER_TIO*t + L.
  always_comb begin
    new_words = '{default: '0};
    new_pend  = '0;
    for (int unsigned t = 0; t < NTIO; t++) begin
      for (int unsigned l = 0; l < SURFS_PER_TIO; l++) begin
        new_words[SURFS_PER_TIO*t+l] = trig_dat_i[16*(LANES_PER_TIO*t+l) +: 16];
        new_pend[SURFS_PER_TIO*t+l]  = trig_dat_i[16*(LANES_PER_TIO*t+l)+15] &
                                       ~trig_mask_i[SURFS_PER_TIO*t+l];
      end
    end
  end

  // Lowest pending SURF is the beat currently presented.
  always_comb begin
    sel_idx  = '0;
    sel_word = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_idx  = 8'(i);
        sel_word = words_q[i];
      end
    end
  end

  assign low_onehot = pend_q & (-pend_q);

  always_comb begin
    handshake = m_trig.tvalid & m_trig.tready;
    pend_left = handshake ? (pend_q & ~low_onehot) : pend_q;
    capture   = slot_hit & (|new_pend);
    // A capture is only taken once the previous one has fully drained,
    // including a drain that finishes on this very clock.
    accept    = capture & ~(|pend_left);
    overflow  = capture & (|pend_left);
    pend_d    = accept ? new_pend : pend_left;
  end

  always_comb begin
    if (overflow_clr_i) begin
      overflow_count_d = {15'd0, overflow};
    end else if (overflow && (overflow_count_q != 16'hFFFF)) begin
      overflow_count_d = overflow_count_q + 16'd1;
    end else begin
      overflow_count_d = overflow_count_q;
    end
  end

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      cnt_q            <= '0;
      locked_q         <= 1'b0;
      pend_q           <= '0;
      overflow_count_q <= '0;
    end else begin
      cnt_q            <= cnt_d;
      locked_q         <= locked_d;
      pend_q           <= pend_d;
      overflow_count_q <= overflow_count_d;
    end
  end

  // Word storage is only observed through pend_q, so it needs no reset.
  always_ff @(posedge sysclk_i) begin
    if (accept) begin
      words_q <= new_words;
    end
  end

  assign m_trig.tvalid    = |pend_q;
  assign m_trig.tlast     = (|pend_q) & (pend_q == low_onehot);
  assign m_trig.tdata     = {sel_idx, sel_word};
  assign overflow_count_o = overflow_count_q;

`ifdef TRIG_SURF_GATHER_PHASE_CHECK_EN
  logic phase_err_q;

  // Once locked, phase must land exactly when the counter wraps to 0.
  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      phase_err_q <= 1'b0;
    end else if (locked_q && ((sysclk_phase_i && (cnt_q != 3'd0)) ||
                              (!sysclk_phase_i && (cnt_q == 3'd0)))) begin
      phase_err_q <= 1'b1;
    end
  end

  assign phase_err_o = phase_err_q;
`else
  assign phase_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_trig_surf_gather.sv
// Self-checking bench for trig_surf_gather: a queue-based reference model of
// the capture/stream rules is compared against the DUT on every negedge, and
// directed scenarios pin literal expected beats.
module tb_trig_surf_gather;

  localparam int NTIO = 4;
  localparam int SPT  = 7;
  localparam int LPT  = 8;
  localparam int NS   = NTIO * SPT;
  localparam int SLOTS = 2;
  localparam int SOFF  = 3;
  localparam int SSP   = 4;

  logic                    clk;
  logic                    rst;
  logic                    phase;
  logic [NTIO*LPT*16-1:0]  trig_dat;
  logic [NS-1:0]           mask;
  logic [15:0]             ovf_cnt;
  logic                    clr;
  logic                    perr;

  trig_surf_gather_if m_trig ();

  trig_surf_gather #(
    .NTIO          (NTIO),
    .SURFS_PER_TIO (SPT),
    .LANES_PER_TIO (LPT),
    .SLOTS         (SLOTS),
    .SLOT_OFFSET   (SOFF),
    .SLOT_SPACING  (SSP)
  ) dut (
    .sysclk_i         (clk),
    .sysclk_rst_i     (rst),
    .sysclk_phase_i   (phase),
    .trig_dat_i       (trig_dat),
    .trig_mask_i      (mask),
    .m_trig           (m_trig),
    .overflow_count_o (ovf_cnt),
    .overflow_clr_i   (clr),
    .phase_err_o      (perr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]  idx;
    logic [15:0] word;
  } beat_t;

  beat_t mq[$];
  beat_t nl[$];
  int    mcnt;
  bit    mlocked;
  int    movf;
  bit    merr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mcnt    = 0;
      mlocked = 0;
      movf    = 0;
      merr    = 0;
    end else begin
      int    p;
      bit    slot;
      bit    ovf;
      beat_t b;
      logic [15:0] w;
      p = phase ? 0 : mcnt;
`ifdef TRIG_SURF_GATHER_PHASE_CHECK_EN
      if (mlocked && ((phase && mcnt != 0) || (!phase && mcnt == 0))) merr = 1;
`endif
      slot = 0;
      if (mlocked)
        for (int k = 0; k < SLOTS; k++)
          if (p == (SOFF + k * SSP) % 8) slot = 1;
      if (mq.size() > 0 && m_trig.tready) void'(mq.pop_front());
      nl.delete();
      for (int s = 0; s < NS; s++) begin
        w = trig_dat[16*(LPT*(s/SPT)+(s%SPT)) +: 16];
        if (w[15] && !mask[s]) begin
          b.idx  = 8'(s);
          b.word = w;
          nl.push_back(b);
        end
      end
      ovf = 0;
      if (slot && nl.size() > 0) begin
        if (mq.size() == 0) mq = nl;
        else ovf = 1;
      end
      if (clr) movf = ovf ? 1 : 0;
      else if (ovf && movf < 65535) movf++;
      if (phase) mlocked = 1;
      mcnt = phase ? 1 : (mcnt + 1) % 8;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("tvalid", {31'd0, m_trig.tvalid}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("tdata", {8'd0, m_trig.tdata}, {8'd0, mq[0].idx, mq[0].word});
      chk("tlast", {31'd0, m_trig.tlast}, {31'd0, mq.size() == 1});
    end
    chk("overflow_count", {16'd0, ovf_cnt}, 32'(movf));
    chk("phase_err", {31'd0, perr}, {31'd0, merr});
  end

  // ---------------- stimulus ----------------
  int cyc      = 0;
  int pbase    = 0;
  bit phase_on = 0;
  logic exp_err;

  function automatic int spos();
    return (cyc - pbase) & 7;
  endfunction

  // Returns 1 time unit after a rising edge; inputs set afterwards apply to
  // the next rising edge, whose command-cycle position is spos().
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    phase = phase_on && (spos() == 0);
  endtask

  task automatic goto_pos(input int p);
    tick();
    while (spos() != p) tick();
  endtask

  task automatic set_surf(input int s, input logic [15:0] w);
    trig_dat[16*(LPT*(s/SPT)+(s%SPT)) +: 16] = w;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    rst = 1'b1;
    phase = 1'b0;
    trig_dat = '0;
    mask = '0;
    clr = 1'b0;
    m_trig.tready = 1'b1;
`ifdef TRIG_SURF_GATHER_PHASE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    repeat (3) tick();
    #2;
    lit("reset_tvalid", {31'd0, m_trig.tvalid}, 32'd0);
    lit("reset_tdata", {8'd0, m_trig.tdata}, 32'd0);
    lit("reset_ovf", {16'd0, ovf_cnt}, 32'd0);
    rst = 1'b0;

    // No capture before the first phase.
    set_surf(0, 16'h8001);
    repeat (12) begin
      tick();
      #2 lit("prelock_tvalid", {31'd0, m_trig.tvalid}, 32'd0);
    end
    trig_dat = '0;

    // Start the phase train.
    phase_on = 1;
    pbase = cyc + 1;

    // Single beat.
    goto_pos(3);
    set_surf(5, 16'h8123);
    tick();
    trig_dat = '0;
    #2;
    lit("single_tvalid", {31'd0, m_trig.tvalid}, 32'd1);
    lit("single_tdata", {8'd0, m_trig.tdata}, 32'h058123);
    lit("single_tlast", {31'd0, m_trig.tlast}, 32'd1);
    tick();
    #2 lit("single_done", {31'd0, m_trig.tvalid}, 32'd0);

    // Three-beat burst.
    goto_pos(3);
    set_surf(0, 16'h8001);
    set_surf(9, 16'h8002);
    set_surf(27, 16'h8003);
    tick();
    trig_dat = '0;
    #2;
    lit("burst_b0", {8'd0, m_trig.tdata}, 32'h008001);
    lit("burst_l0", {31'd0, m_trig.tlast}, 32'd0);
    tick();
    #2;
    lit("burst_b1", {8'd0, m_trig.tdata}, 32'h098002);
    lit("burst_l1", {31'd0, m_trig.tlast}, 32'd0);
    tick();
    #2;
    lit("burst_b2", {8'd0, m_trig.tdata}, 32'h1B8003);
    lit("burst_l2", {31'd0, m_trig.tlast}, 32'd1);
    tick();
    #2 lit("burst_done", {31'd0, m_trig.tvalid}, 32'd0);

    // Masking and bit 15 clear.
    goto_pos(3);
    mask[9] = 1'b1;
    set_surf(9, 16'h8AAA);
    set_surf(10, 16'h8BBB);
    tick();
    trig_dat = '0;
    mask = '0;
    #2;
    lit("mask_tdata", {8'd0, m_trig.tdata}, 32'h0A8BBB);
    lit("mask_tlast", {31'd0, m_trig.tlast}, 32'd1);
    tick();
    goto_pos(7);
    set_surf(3, 16'h7FFF);
    tick();
    trig_dat = '0;
    #2 lit("nobit15", {31'd0, m_trig.tvalid}, 32'd0);

    // Overflow, saturation, clear dominance.
    m_trig.tready = 1'b0;
    goto_pos(3);
    set_surf(2, 16'h8222);
    set_surf(4, 16'h8444);
    tick();
    trig_dat = '0;
    set_surf(6, 16'h8666);
    goto_pos(7);
    tick();
    #2;
    lit("ovf_one", {16'd0, ovf_cnt}, 32'd1);
    lit("ovf_hold", {8'd0, m_trig.tdata}, 32'h028222);
    force dut.overflow_count_q = 16'hFFFE;
    movf = 16'hFFFE;
    #1 release dut.overflow_count_q;
    goto_pos(3);
    tick();
    #2 lit("ovf_sat", {16'd0, ovf_cnt}, 32'hFFFF);
    goto_pos(7);
    tick();
    #2 lit("ovf_sat_hold", {16'd0, ovf_cnt}, 32'hFFFF);
    goto_pos(3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    trig_dat = '0;
    #2;
    lit("ovf_clr_plus", {16'd0, ovf_cnt}, 32'd1);
    lit("ovf_data_kept", {8'd0, m_trig.tdata}, 32'h028222);
    m_trig.tready = 1'b1;
    tick();
    #2;
    lit("drain_b1", {8'd0, m_trig.tdata}, 32'h048444);
    lit("drain_l1", {31'd0, m_trig.tlast}, 32'd1);
    tick();
    #2 lit("drain_done", {31'd0, m_trig.tvalid}, 32'd0);

    // tlast handshake coincident with slot: new capture accepted.
    goto_pos(3);
    m_trig.tready = 1'b0;
    set_surf(1, 16'h8111);
    tick();
    trig_dat = '0;
    goto_pos(7);
    m_trig.tready = 1'b1;
    set_surf(8, 16'h8888);
    tick();
    trig_dat = '0;
    #2;
    lit("coincide_tdata", {8'd0, m_trig.tdata}, 32'h088888);
    lit("coincide_ovf", {16'd0, ovf_cnt}, 32'd1);
    tick();
    #2 lit("coincide_done", {31'd0, m_trig.tvalid}, 32'd0);

    // Reset mid-burst.
    goto_pos(3);
    set_surf(0, 16'h8001);
    set_surf(9, 16'h8002);
    set_surf(27, 16'h8003);
    tick();
    trig_dat = '0;
    tick();
    #1 rst = 1'b1;
    #1 lit("rst_mid_tvalid", {31'd0, m_trig.tvalid}, 32'd0);
    phase_on = 0;
    tick();
    rst = 1'b0;
    set_surf(0, 16'h8001);
    repeat (12) begin
      tick();
      #2 lit("post_rst_idle", {31'd0, m_trig.tvalid}, 32'd0);
    end
    trig_dat = '0;

    // Phase spacing error.
    phase_on = 1;
    pbase = cyc + 1;
    repeat (16) tick();
    #2 lit("perr_clean", {31'd0, perr}, 32'd0);
    pbase = pbase + 2;
    repeat (20) tick();
    #2 lit("perr_set", {31'd0, perr}, {31'd0, exp_err});
    repeat (8) tick();
    #2 lit("perr_sticky", {31'd0, perr}, {31'd0, exp_err});

    // Randomized traffic.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    pbase = cyc + 1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < NTIO * LPT; i++) begin
        logic [15:0] w;
        w = 16'($urandom);
        w[15] = ($urandom_range(0, 5) == 0);
        trig_dat[16*i +: 16] = w;
      end
      for (int s = 0; s < NS; s++) mask[s] = ($urandom_range(0, 3) == 0);
      m_trig.tready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
    end
    trig_dat = '0;
    clr = 1'b0;
    m_trig.tready = 1'b1;
    repeat (40) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
